// File: rtl/code_8_3_if.sv
// Request/result bundle for the code_8_3 dual priority encoder.
// din: 8-bit request vector, dout: registered encoded result.
interface code_8_3_if;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (
        output din,
        input  dout
    );

    modport slave (
        input  din,
        output dout
    );
endinterface

// File: rtl/code_8_3.sv
// Dual priority encoder: high/low set-bit index, valid and multiple flags.
// Ports: clk, rst (sync, active-high), bus.din in, bus.dout registered out.
module code_8_3 (
    input  logic       clk,
    input  logic       rst,
    code_8_3_if.slave  bus
);

    logic [2:0] hi_idx;
    logic [2:0] lo_idx;
    logic       valid;
    logic       multi;

    // Ascending scan: the last set bit seen is the highest.
    // Descending scan: the last set bit seen is the lowest.
    always_comb begin
        hi_idx = 3'd0;
        lo_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (bus.din[i]) begin
                hi_idx = i[2:0];
            end
        end
        for (int i = 7; i >= 0; i--) begin
            if (bus.din[i]) begin
                lo_idx = i[2:0];
            end
        end
    end

    assign valid = |bus.din;
    // Clearing the lowest set bit leaves something only if 2+ bits were set.
    assign multi = |(bus.din & (bus.din - 8'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dout <= 8'h00;
        end else begin
            bus.dout <= {lo_idx, multi, valid, hi_idx};
        end
    end

endmodule

// File: tb/tb_code_8_3.sv
// Directed and exhaustive checks for code_8_3.
// Drives din #1 after each rising edge and checks dout one edge later.
module tb_code_8_3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    code_8_3_if bus ();

    code_8_3 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [7:0] d);
        int  h;
        int  l;
        bit  hf;
        bit  lf;
        logic m;
        logic v;
        h  = 0;
        l  = 0;
        hf = 0;
        lf = 0;
        for (int i = 7; i >= 0; i--) begin
            if (!hf && d[i]) begin
                h  = i;
                hf = 1;
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (!lf && d[i]) begin
                l  = i;
                lf = 1;
            end
        end
        m = ($countones(d) > 1);
        v = (d != 8'h00);
        return {l[2:0], m, v, h[2:0]};
    endfunction

    task automatic check(input string tag, input logic [7:0] exp);
        checks++;
        assert (bus.dout === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, bus.dout, exp);
        end
    endtask

    // Apply din, advance one edge, sample 1 time unit later.
    task automatic step(input logic [7:0] d);
        bus.din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        bus.din = 8'hA5;

        step(8'hA5);
        check("reset_state", 8'h00);
        step(8'h80);
        check("reset_hold", 8'h00);

        rst = 1'b0;
        step(8'b0000_0000);
        check("idle", 8'b0000_0000);
        step(8'b1000_0000);
        check("top_only", 8'b1110_1111);
        step(8'b0000_0001);
        check("bottom_only", 8'b0000_1000);
        step(8'b1000_0001);
        check("top_bottom", 8'b0001_1111);
        step(8'b0010_1100);
        check("three_bits", 8'b0101_1101);
        step(8'b0001_0000);
        check("single_4", 8'b1000_1100);
        step(8'b0110_0000);
        check("bits_6_5", 8'b1011_1110);

        bus.din = 8'hFF;
        rst = 1'b1;
        step(8'hFF);
        check("mid_rst_1", 8'h00);
        step(8'hFF);
        check("mid_rst_2", 8'h00);
        rst = 1'b0;
        step(8'hFF);
        check("post_rst", 8'b0001_1111);

        for (int v = 0; v < 256; v++) begin
            step(v[7:0]);
            check($sformatf("sweep_%02h", v[7:0]), model(v[7:0]));
        end

        step(8'h00);
        check("final_idle", 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
